// File: rtl/mmio_cmd_sink.sv
// MMIO store sink: TXCMD stores enter a DEPTH-entry FIFO drained over cmd_valid/cmd_ready; STATUS is read back 1 cycle later.
// A full FIFO drops the store, sets sticky ovf and counts drops. The head word holds while cmd_ready is low.
module mmio_cmd_sink #(
   parameter int                DEPTH  = 8,
   parameter int                ADDR_W = 12,
   parameter logic [ADDR_W-1:0] BASE   = 12'hFF0
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] address_dmem,
   input  logic [31:0]       data,
   input  logic              wren,
   output logic              mmio_sel,
   output logic [31:0]       q_mmio,
   output logic              cmd_valid,
   output logic [31:0]       cmd_data,
   input  logic              cmd_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic          ovf;
   logic [7:0]    drops;
   logic [31:0]   mem [DEPTH];

   logic [1:0]  offset;
   logic        full;
   logic        empty;
   logic        push_req;
   logic        push;
   logic        pop;
   logic        clr;
   logic [31:0] status;

   assign offset    = address_dmem[1:0];
   assign mmio_sel  = (address_dmem[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
   assign full      = (count == CNT_FULL);
   assign empty     = (count == '0);
   assign push_req  = wren & mmio_sel & (offset == 2'd0);
   // Acceptance looks only at occupancy at the start of the cycle, so a same-cycle pop cannot rescue a push into a full FIFO.
   assign push      = push_req & ~full;
   assign pop       = cmd_valid & cmd_ready;
   assign clr       = wren & mmio_sel & (offset == 2'd2) & data[0];
   assign status    = {drops, 8'h00, 8'(count), 5'b0, ovf, full, empty};
   assign cmd_valid = ~empty;
   assign cmd_data  = mem[head];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         drops  <= 8'h00;
         q_mmio <= 32'h0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      end else begin
         if (push) begin
            mem[tail] <= data;
            tail      <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (push_req && full) begin
            ovf <= 1'b1;
            if (drops != 8'hFF) drops <= drops + 1'b1;
         end else if (clr) begin
            ovf   <= 1'b0;
            drops <= 8'h00;
         end
         q_mmio <= (mmio_sel && offset == 2'd1) ? status : 32'h0;
      end
   end

endmodule

// File: tb/tb_mmio_cmd_sink.sv
// Bench for mmio_cmd_sink: vector table for register access plus hand sequences, with a queue scoreboard on the command port.
module tb_mmio_cmd_sink;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [11:0] address_dmem = 12'h0;
   logic [31:0] data = 32'h0;
   logic        wren = 1'b0;
   logic        cmd_ready = 1'b0;
   logic        mmio_sel;
   logic [31:0] q_mmio;
   logic        cmd_valid;
   logic [31:0] cmd_data;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q [$];
   logic        acc;

   always #5 clock = ~clock;

   mmio_cmd_sink dut (
      .clock(clock), .resetn(resetn), .address_dmem(address_dmem), .data(data),
      .wren(wren), .mmio_sel(mmio_sel), .q_mmio(q_mmio), .cmd_valid(cmd_valid),
      .cmd_data(cmd_data), .cmd_ready(cmd_ready)
   );

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] dat;
      logic        rdy;
      logic        sel;
      logic [31:0] q;
      logic        vld;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(logic wr, logic [11:0] addr, logic [31:0] dat, logic rdy,
                               logic sel, logic [31:0] q, logic vld);
      vec_t v;
      v.wr = wr; v.addr = addr; v.dat = dat; v.rdy = rdy; v.sel = sel; v.q = q; v.vld = vld;
      return v;
   endfunction

   task automatic drive(input logic wr, input logic [11:0] addr, input logic [31:0] dat, input logic rdy);
      wren = wr; address_dmem = addr; data = dat; cmd_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply(input vec_t v);
      drive(v.wr, v.addr, v.dat, v.rdy);
      @(negedge clock);
      chk("mmio_sel", 32'(mmio_sel), 32'(v.sel));
      tick();
      chk("q_mmio", q_mmio, v.q);
      chk("cmd_valid_vec", 32'(cmd_valid), 32'(v.vld));
   endtask

   task automatic drain();
      drive(1'b0, 12'h000, 32'h0, 1'b1);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
      end
      drive(1'b0, 12'h000, 32'h0, 1'b0);
      chk("drained_valid", 32'(cmd_valid), 32'h0);
   endtask

   task automatic read_status(input string name, input logic [31:0] exp);
      drive(1'b0, 12'hFF1, 32'h0, 1'b0);
      tick();
      chk(name, q_mmio, exp);
   endtask

   // Scoreboard: inputs are stable at the falling edge, so this sees exactly what the next rising edge will act on.
   always @(negedge clock) begin
      if (resetn) begin
         acc = wren && (address_dmem == 12'hFF0) && (exp_q.size() < 8);
         chk("cmd_valid", 32'(cmd_valid), 32'(exp_q.size() != 0));
         if (cmd_valid && exp_q.size() != 0) chk("cmd_data", cmd_data, exp_q[0]);
         if (cmd_valid && cmd_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(data);
      end
   end

   initial begin
      vecs.push_back(mk(1'b0, 12'hFF1, 32'h0,       1'b0, 1'b1, 32'h0000_0001, 1'b0));
      vecs.push_back(mk(1'b1, 12'hFEF, 32'h55,      1'b0, 1'b0, 32'h0,         1'b0));
      vecs.push_back(mk(1'b1, 12'hFF3, 32'h66,      1'b0, 1'b1, 32'h0,         1'b0));
      vecs.push_back(mk(1'b1, 12'hFF1, 32'hFFFF,    1'b0, 1'b1, 32'h0000_0001, 1'b0));
      vecs.push_back(mk(1'b0, 12'hFF3, 32'h0,       1'b0, 1'b1, 32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 12'h000, 32'h0,       1'b1, 1'b0, 32'h0,         1'b0));
      vecs.push_back(mk(1'b1, 12'hFF0, 32'hDEADBEEF,1'b0, 1'b1, 32'h0,         1'b1));

      repeat (3) tick();
      chk("reset_valid", 32'(cmd_valid), 32'h0);
      chk("reset_q", q_mmio, 32'h0);
      resetn = 1'b1;
      tick();

      foreach (vecs[i]) apply(vecs[i]);

      drive(1'b0, 12'h000, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("hold_valid", 32'(cmd_valid), 32'h1);
         chk("hold_data", cmd_data, 32'hDEADBEEF);
         tick();
      end
      drive(1'b0, 12'h000, 32'h0, 1'b1);
      tick();
      drive(1'b0, 12'h000, 32'h0, 1'b0);
      chk("pop_valid", 32'(cmd_valid), 32'h0);

      vecs.delete();
      for (int i = 1; i <= 10; i++)
         vecs.push_back(mk(1'b1, 12'hFF0, 32'(i), 1'b0, 1'b1, 32'h0, 1'b1));
      vecs.push_back(mk(1'b0, 12'hFF1, 32'h0, 1'b0, 1'b1, 32'h0200_0806, 1'b1));
      foreach (vecs[i]) apply(vecs[i]);

      drive(1'b1, 12'hFF0, 32'd99, 1'b1);
      tick();
      read_status("full_push_pop_status", 32'h0300_0704);
      drain();

      drive(1'b1, 12'hFF2, 32'h2, 1'b0);
      tick();
      read_status("clear_bit0_low", 32'h0300_0005);
      drive(1'b1, 12'hFF2, 32'h1, 1'b0);
      tick();
      read_status("clear_status", 32'h0000_0001);

      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 12'hFF0, 32'h100 + 32'(i), 1'($urandom_range(0, 1)));
         tick();
      end
      drain();

      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 12'hFF0, 32'hA0 + 32'(i), 1'b0);
         tick();
      end
      drive(1'b0, 12'h000, 32'h0, 1'b0);
      resetn = 1'b0;
      #1;
      chk("async_reset_valid", 32'(cmd_valid), 32'h0);
      chk("async_reset_q", q_mmio, 32'h0);
      exp_q.delete();
      tick();
      resetn = 1'b1;
      tick();
      read_status("post_reset_status", 32'h0000_0001);
      chk("post_reset_valid", 32'(cmd_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_cmd_sink.md
# mmio_cmd_sink

Memory-mapped store responder on the processor data-memory port. Captures processor stores (`sw`, the opcode that asserts the data-memory write enable) aimed at a small MMIO window, queues them as 32-bit command words in a FIFO, and drains them to a downstream robot-actuation controller over a valid/ready handshake. A status register is readable through the same port, so software can poll occupancy and overflow.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `ADDR_W`, 12: data-memory address width.
- `BASE`, 12'hFF0: window base; window spans `BASE`..`BASE+3`; `BASE[1:0]` must be 0.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `address_dmem`  in  ADDR_W  processor data-memory address.
- `data`  in  32  processor store data.
- `wren`  in  1  processor data-memory write enable.
- `mmio_sel`  out  1  combinational; 1 when `address_dmem` lies in the window. The top level uses it to steer `q_dmem` and to suppress the RAM write.
- `q_mmio`  out  32  registered read data.
- `cmd_valid`  out  1  FIFO non-empty.
- `cmd_data`  out  32  FIFO head word.
- `cmd_ready`  in  1  downstream accepts the head word.

## Operation
- Register offsets (`address_dmem - BASE`):
  - 0 `TXCMD`: a store pushes `data`.
  - 1 `STATUS`: read-only; stores are ignored.
  - 2 `CLEAR`: a store with `data[0]=1` clears `ovf` and `drops`.
  - 3: reserved; reads return 0 and stores are ignored.
- Push event: `wren & mmio_sel & offset==0`.
  - Accepted iff `count < DEPTH` at the start of the cycle.
  - If not accepted, the word is dropped, `ovf` sets (sticky), and `drops` increments, saturating at 255.
  - A full FIFO rejects the push even if a pop happens in the same cycle.
- Pop event: `cmd_valid & cmd_ready`. The head advances and `count` decrements.
- Simultaneous accepted push and pop: `count` is unchanged and both pointers advance.
- Storage and pointers:
  - `head`/`tail` are log2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits, 0..DEPTH.
- `cmd_valid = (count != 0)`. `cmd_data = mem[head]`, driven directly from the storage registers.
- `cmd_data` must hold stable while `cmd_valid & !cmd_ready`.
- STATUS word layout:
  - bit0 `empty`, bit1 `full`, bit2 `ovf`.
  - [15:8] `count`, zero-extended.
  - [31:24] `drops`.
  - All other bits 0.
- CLEAR coinciding with an overflow drop in the same cycle cannot occur, because each cycle carries a single store. CLEAR takes effect on the following edge.
- Reset (`resetn=0`, async):
  - `head`, `tail`, `count`, `ovf`, `drops` and `q_mmio` go to 0.
  - `cmd_valid` goes to 0.
  - FIFO contents are don't-care, but `cmd_data` must not be X-propagating in simulation; zero the storage.
- Reset mid-transfer discards all queued words. Downstream must treat `cmd_valid` falling as a flush.

## Timing
- `mmio_sel`: combinational, same cycle as the address.
- Read latency is 1 cycle: `q_mmio` on edge N+1 reflects the address and state sampled at edge N. It reflects state before any push/pop of that same edge.
- When `mmio_sel=0`, `q_mmio` registers 0.
- Push-to-valid: a word pushed at edge N is visible on `cmd_valid`/`cmd_data` after edge N, i.e. 1 cycle latency into an empty FIFO.
- Sustained throughput: one push and one pop per cycle.
- `cmd_ready` may be asserted without `cmd_valid`; it has no effect.
- No combinational path from `cmd_ready` to `cmd_valid` or `cmd_data`.

## Test plan
- Reset and status:
  - Stimulus: assert `resetn=0`, release, then read `STATUS`.
  - Required response: `cmd_valid=0`; `q_mmio=32'h0000_0001` one cycle after the read.
- Single command:
  - Stimulus: store `32'hDEAD_BEEF` to `BASE` with `cmd_ready=0`.
  - Required response: the next cycle shows `cmd_valid=1` and `cmd_data=32'hDEAD_BEEF`, held for 5 cycles. Raising `cmd_ready` for 1 cycle pops it and `cmd_valid` drops.
- Fill and overflow (DEPTH=8):
  - Stimulus: 10 stores of 1..10 with `cmd_ready=0`.
  - Required response: STATUS reads `32'h0200_0806` (drops=2, count=8, full, ovf). Draining yields exactly 1..8 in order.
- Full with simultaneous pop:
  - Stimulus: with the FIFO full, push and pop in the same cycle.
  - Required response: the push is dropped, `count=7`, `drops` increments.
- Wrap-around and concurrency:
  - Stimulus: 40 cycles with a push every cycle and `cmd_ready` toggling pseudo-randomly.
  - Required response: the output sequence equals the accepted input sequence, and `count` never exceeds 8.
- Clear and mid-operation reset:
  - Stimulus: after an overflow, store 1 to `BASE+2`; then pulse `resetn` low with 3 words queued.
  - Required response: after the clear, STATUS shows `ovf=0` and `drops=0`. After the reset pulse, `cmd_valid=0` immediately (asynchronous), and STATUS is `32'h0000_0001`.
